// File: rtl/strobe_serializer.sv
`default_nettype none
// ============================================================================
// Module      : strobe_serializer
// Description : Transmit side of a strobe-captured serial bit link. Accepts a
//               parallel word on a valid/ready handshake and shifts it out
//               MSB-first on ser_data, with one ser_strb pulse per bit. The
//               receiving flop clocks on the rising edge of ser_strb. Data is
//               therefore held stable across every strobe rising edge.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH    bits per word (2..32)
//   DIV      clk cycles per strobe half-period, low and high (>= 1)
// Ports
//   clk      in   1      system clock, all logic on rising edge
//   reset    in   1      synchronous, active-high
//   in_valid in   1      word offered
//   in_data  in   WIDTH  word to send, sampled only on handshake
//   in_ready out  1      block can accept a word
//   ser_data out  1      serial data, MSB first
//   ser_strb out  1      strobe, receiver captures on rising edge
//   frame    out  1      high while a word is being shifted
//   done     out  1      one-cycle pulse after the last strobe high phase
// ============================================================================
module strobe_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_data,
    output logic             ser_strb,
    output logic             frame,
    output logic             done
);

    localparam int PW = $clog2(DIV + 1);
    localparam int BW = $clog2(WIDTH);

    localparam logic [PW-1:0] c_PH_LAST  = PW'(DIV - 1);
    localparam logic [BW-1:0] c_BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_HIGH  = 2'd2
    } state_t;

    state_t           state_q;
    // Only the bits still to be sent are kept: the MSB goes straight to
    // ser_data_q on the handshake edge.
    logic [WIDTH-2:0] shreg_q;
    logic [BW-1:0]    bitcnt_q;
    logic [PW-1:0]    phase_q;

    logic             in_ready_q;
    logic             ser_data_q;
    logic             ser_strb_q;
    logic             frame_q;
    logic             done_q;

    assign in_ready = in_ready_q;
    assign ser_data = ser_data_q;
    assign ser_strb = ser_strb_q;
    assign frame    = frame_q;
    assign done     = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            phase_q    <= '0;
            in_ready_q <= 1'b1;
            ser_data_q <= 1'b0;
            ser_strb_q <= 1'b0;
            frame_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        shreg_q    <= in_data[WIDTH-2:0];
                        ser_data_q <= in_data[WIDTH-1];
                        bitcnt_q   <= '0;
                        phase_q    <= '0;
                        frame_q    <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    // Data has been stable for DIV cycles when the strobe rises.
                    if (phase_q == c_PH_LAST) begin
                        phase_q    <= '0;
                        ser_strb_q <= 1'b1;
                        state_q    <= S_HIGH;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end

                S_HIGH: begin
                    if (phase_q == c_PH_LAST) begin
                        phase_q    <= '0;
                        ser_strb_q <= 1'b0;
                        if (bitcnt_q != c_BIT_LAST) begin
                            // Next bit appears on the same edge the strobe falls.
                            ser_data_q <= shreg_q[WIDTH-2];
                            shreg_q    <= shreg_q << 1;
                            bitcnt_q   <= bitcnt_q + 1'b1;
                            state_q    <= S_SETUP;
                        end else begin
                            ser_data_q <= 1'b0;
                            shreg_q    <= '0;
                            bitcnt_q   <= '0;
                            frame_q    <= 1'b0;
                            in_ready_q <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= S_IDLE;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    shreg_q    <= '0;
                    bitcnt_q   <= '0;
                    phase_q    <= '0;
                    in_ready_q <= 1'b1;
                    ser_data_q <= 1'b0;
                    ser_strb_q <= 1'b0;
                    frame_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_strobe_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_strobe_serializer
// Description : Directed self-checking bench for strobe_serializer. One
//               instance at WIDTH=8/DIV=2, one at WIDTH=2/DIV=1. A receiver
//               model shifts in ser_data on every strobe rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_strobe_serializer;

    logic       clk = 1'b0;
    logic       reset;

    logic       a_valid;
    logic [7:0] a_in;
    logic       a_ready, a_data, a_strb, a_frame, a_done;

    logic       b_valid;
    logic [1:0] b_in;
    logic       b_ready, b_data, b_strb, b_frame, b_done;

    int         n_assert = 0;
    int         n_fail   = 0;

    logic       a_prev_strb = 1'b0, a_prev_data = 1'b0;
    logic       b_prev_strb = 1'b0, b_prev_data = 1'b0;
    logic [7:0] rx_a;
    logic [1:0] rx_b;
    int         rx_a_n, rx_b_n;

    always #5 clk = ~clk;

    strobe_serializer #(.WIDTH(8), .DIV(2)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .in_valid (a_valid),
        .in_data  (a_in),
        .in_ready (a_ready),
        .ser_data (a_data),
        .ser_strb (a_strb),
        .frame    (a_frame),
        .done     (a_done)
    );

    strobe_serializer #(.WIDTH(2), .DIV(1)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .in_valid (b_valid),
        .in_data  (b_in),
        .in_ready (b_ready),
        .ser_data (b_data),
        .ser_strb (b_strb),
        .frame    (b_frame),
        .done     (b_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, then run the link checker and the
    // receiver model for both instances.
    task automatic tick();
        @(negedge clk);
        if (a_strb && !a_prev_strb) begin
            check("a_data_stable_at_rise", 32'(a_data), 32'(a_prev_data));
            rx_a = {rx_a[6:0], a_data};
            rx_a_n++;
        end
        if (a_strb) check("a_frame_with_strb", 32'(a_frame), 32'd1);
        if (b_strb && !b_prev_strb) begin
            check("b_data_stable_at_rise", 32'(b_data), 32'(b_prev_data));
            rx_b = {rx_b[0], b_data};
            rx_b_n++;
        end
        if (b_strb) check("b_frame_with_strb", 32'(b_frame), 32'd1);
        a_prev_strb = a_strb;
        a_prev_data = a_data;
        b_prev_strb = b_strb;
        b_prev_data = b_data;
    endtask

    task automatic check_idle_a(input logic exp_done);
        check("a_idle_ready", 32'(a_ready), 32'd1);
        check("a_idle_strb",  32'(a_strb),  32'd0);
        check("a_idle_data",  32'(a_data),  32'd0);
        check("a_idle_frame", 32'(a_frame), 32'd0);
        check("a_idle_done",  32'(a_done),  32'(exp_done));
    endtask

    // Called at the falling edge of the first frame cycle (k=0). Checks every
    // cycle of the frame against the expected waveform and ends at the done
    // cycle. With abort_k >= 0, reset is asserted at that cycle (with a new
    // word offered) and the task returns with reset released and in_valid high.
    task automatic run_frame_a(input logic [7:0] w, input bit inject, input int abort_k);
        rx_a   = '0;
        rx_a_n = 0;
        for (int k = 0; k < 32; k++) begin
            if (k == abort_k) begin
                reset   = 1'b1;
                a_valid = 1'b1;
                a_in    = 8'h81;
                tick();
                check_idle_a(1'b0);
                tick();
                check_idle_a(1'b0);
                reset = 1'b0;
                return;
            end
            check("a_frame_strb",  32'(a_strb),  32'((k % 4) >= 2));
            check("a_frame_data",  32'(a_data),  32'(w[7 - k / 4]));
            check("a_frame_frame", 32'(a_frame), 32'd1);
            check("a_frame_ready", 32'(a_ready), 32'd0);
            check("a_frame_done",  32'(a_done),  32'd0);
            if (inject && k == 4) begin
                a_valid = 1'b1;
                a_in    = 8'h3C;
            end
            if (inject && k == 12) a_valid = 1'b0;
            tick();
        end
        check_idle_a(1'b1);
        check("a_rx_word", 32'(rx_a),  32'(w));
        check("a_rx_bits", 32'(rx_a_n), 32'd8);
    endtask

    task automatic run_frame_b(input logic [1:0] w);
        rx_b   = '0;
        rx_b_n = 0;
        for (int k = 0; k < 4; k++) begin
            check("b_frame_strb",  32'(b_strb),  32'(k % 2));
            check("b_frame_data",  32'(b_data),  32'(w[1 - k / 2]));
            check("b_frame_frame", 32'(b_frame), 32'd1);
            check("b_frame_ready", 32'(b_ready), 32'd0);
            tick();
        end
        check("b_done",       32'(b_done),  32'd1);
        check("b_done_frame", 32'(b_frame), 32'd0);
        check("b_done_strb",  32'(b_strb),  32'd0);
        check("b_done_ready", 32'(b_ready), 32'd1);
        check("b_rx_word",    32'(rx_b),    32'(w));
        check("b_rx_bits",    32'(rx_b_n),  32'd2);
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0;
        a_in    = 8'h00;
        b_valid = 1'b0;
        b_in    = 2'b00;
        rx_a    = '0;
        rx_b    = '0;
        rx_a_n  = 0;
        rx_b_n  = 0;
        tick();
        tick();
        check_idle_a(1'b0);
        check("b_rst_ready", 32'(b_ready), 32'd1);
        check("b_rst_strb",  32'(b_strb),  32'd0);
        check("b_rst_data",  32'(b_data),  32'd0);
        check("b_rst_frame", 32'(b_frame), 32'd0);
        check("b_rst_done",  32'(b_done),  32'd0);
        reset = 1'b0;
        tick();
        check_idle_a(1'b0);

        // Single word 0xA5
        a_valid = 1'b1;
        a_in    = 8'hA5;
        tick();
        a_valid = 1'b0;
        run_frame_a(8'hA5, 1'b0, -1);
        tick();
        check_idle_a(1'b0);

        // Back-to-back 0xFF then 0x00 with in_valid held high
        a_valid = 1'b1;
        a_in    = 8'hFF;
        tick();
        run_frame_a(8'hFF, 1'b0, -1);
        a_in = 8'h00;
        tick();
        a_valid = 1'b0;
        run_frame_a(8'h00, 1'b0, -1);
        tick();
        check_idle_a(1'b0);

        // Word offered while busy is ignored
        a_valid = 1'b1;
        a_in    = 8'h5A;
        tick();
        a_valid = 1'b0;
        run_frame_a(8'h5A, 1'b1, -1);
        tick();
        check_idle_a(1'b0);

        // Reset in bit 3 of 0x81, reset wins over in_valid, then a clean 0x81
        a_valid = 1'b1;
        a_in    = 8'h81;
        tick();
        a_valid = 1'b0;
        run_frame_a(8'h81, 1'b0, 13);
        tick();
        a_valid = 1'b0;
        run_frame_a(8'h81, 1'b0, -1);
        tick();
        check_idle_a(1'b0);

        // Minimal configuration: WIDTH=2, DIV=1
        b_valid = 1'b1;
        b_in    = 2'b10;
        tick();
        b_valid = 1'b0;
        run_frame_b(2'b10);
        tick();
        b_valid = 1'b1;
        b_in    = 2'b01;
        tick();
        b_valid = 1'b0;
        run_frame_b(2'b01);
        tick();
        check("b_final_frame", 32'(b_frame), 32'd0);
        check("b_final_done",  32'(b_done),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
